// File: rtl/pc_gen.sv
// ----------------------------------------------------------------------------
// pc_gen -- program-counter generator for the front of the fetch stage.
//
// Holds the word-aligned fetch address and picks the next one each cycle.
// Sources, in priority order:
//   exception vector > exception return > redirect > RAS pop > stall > +1.
// A three-state FSM (BOOT / RUN / EXC) tracks whether a valid fetch address
// is being produced and whether an exception handler is running. Exceptions
// do not nest.
//
// Optional feature macro: PC_RAS_EN
//   When defined, a RAS_DEPTH-entry circular return-address stack is built.
//   A call that redirects pushes pc+1. A ret pops the top entry into pc.
//   When undefined, i_call and i_ret are ignored and o_ras_uflow is tied 0.
//
// Parameters
//   AW         byte-address width; every address port is AW-2 bits wide
//   RESET_VEC  word address loaded on reset
//   EXC_VEC    word address of the exception handler
//   RAS_DEPTH  return-stack entries (power of 2, >= 2); PC_RAS_EN only
//
// Ports
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_stall         hold pc this cycle
//   i_redirect_vld  branch/jump taken
//   i_redirect_pc   branch/jump target (word address)
//   i_exc_req       exception raised by the instruction at the current pc
//   i_eret          return from exception
//   i_call          the current redirect is a call (PC_RAS_EN)
//   i_ret           the current instruction is a return (PC_RAS_EN)
//   o_pc            current fetch word address (registered)
//   o_pc_vld        o_pc is a valid fetch address (registered)
//   o_epc           saved pc of the excepting instruction (registered)
//   o_in_exc        FSM is in EXC (registered)
//   o_ras_uflow     one-cycle pulse after a ret on an empty stack
// ----------------------------------------------------------------------------
module pc_gen #(
   parameter int unsigned     AW        = 32,
   parameter logic [AW-3:0]   RESET_VEC = 'h0c00,
   parameter logic [AW-3:0]   EXC_VEC   = 'h1060,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_stall,
   input  logic          i_redirect_vld,
   input  logic [AW-3:0] i_redirect_pc,
   input  logic          i_exc_req,
   input  logic          i_eret,
   input  logic          i_call,
   input  logic          i_ret,
   output logic [AW-3:0] o_pc,
   output logic          o_pc_vld,
   output logic [AW-3:0] o_epc,
   output logic          o_in_exc,
   output logic          o_ras_uflow
);

   localparam int unsigned PW = AW - 2;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_EXC  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [PW-1:0]  r_pc;
   logic [PW-1:0]  w_pc_next;
   logic [PW-1:0]  w_pc_inc;
   logic [PW-1:0]  r_epc;
   logic [PW-1:0]  w_epc_next;
   logic           r_pc_vld;
   logic           r_in_exc;

   // Plain modular increment; the all-ones address wraps to zero silently.
   assign w_pc_inc = r_pc + PW'(1);

`ifdef PC_RAS_EN
   localparam int unsigned RAS_AW = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
   localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW + 1)'(RAS_DEPTH);

   // r_ras_ptr points at the slot the next push writes. The top of stack
   // therefore sits one below it. Pushing onto a full stack simply walks
   // over the oldest entry, since the pointer wraps and the count saturates.
   logic [PW-1:0]     r_ras [RAS_DEPTH];
   logic [RAS_AW-1:0] r_ras_ptr;
   logic [RAS_AW-1:0] w_ras_top_idx;
   logic [RAS_AW:0]   r_ras_cnt;
   logic [PW-1:0]     w_ras_top;
   logic              w_ras_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_uflow;
   logic              r_ras_uflow;

   assign w_ras_top_idx = r_ras_ptr - RAS_AW'(1);
   assign w_ras_top     = r_ras[w_ras_top_idx];
   assign w_ras_empty   = (r_ras_cnt == '0);
`endif

   // ------------------------------------------------------------------
   // Next-state / next-pc selection
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_epc_next   = r_epc;
`ifdef PC_RAS_EN
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_uflow      = 1'b0;
`endif
      unique case (r_state)
         // BOOT lasts exactly one cycle. Every input is ignored, and pc
         // stays at RESET_VEC so that RESET_VEC becomes the first fetch.
         ST_BOOT: begin
            w_state_next = ST_RUN;
         end
         ST_RUN, ST_EXC: begin
            if (i_exc_req && (r_state == ST_RUN)) begin
               w_pc_next    = EXC_VEC;
               w_epc_next   = r_pc;
               w_state_next = ST_EXC;
            end else if (i_eret && (r_state == ST_EXC)) begin
               w_pc_next    = r_epc;
               w_state_next = ST_RUN;
            end else if (i_redirect_vld) begin
               // A redirect beats a stall. When a call and a ret arrive
               // together, the call's push is the only stack action.
               w_pc_next = i_redirect_pc;
`ifdef PC_RAS_EN
               w_push    = i_call;
`endif
            end
`ifdef PC_RAS_EN
            else if (i_ret) begin
               if (!w_ras_empty) begin
                  w_pc_next = w_ras_top;
                  w_pop     = 1'b1;
               end else begin
                  // There is nothing to predict from, so fall through
                  // sequentially and flag the underflow.
                  w_pc_next = w_pc_inc;
                  w_uflow   = 1'b1;
               end
            end
`endif
            else if (i_stall) begin
               w_pc_next = r_pc;
            end else begin
               w_pc_next = w_pc_inc;
            end
         end
         default: begin
            w_state_next = ST_BOOT;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_BOOT;
         r_pc     <= RESET_VEC;
         r_epc    <= '0;
         r_pc_vld <= 1'b0;
         r_in_exc <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_pc     <= w_pc_next;
         r_epc    <= w_epc_next;
         // Status flags are decoded from the next state. This keeps them
         // registered and cycle-aligned with r_state.
         r_pc_vld <= (w_state_next != ST_BOOT);
         r_in_exc <= (w_state_next == ST_EXC);
      end
   end

`ifdef PC_RAS_EN
   // ------------------------------------------------------------------
   // Return-address stack
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ras_ptr   <= '0;
         r_ras_cnt   <= '0;
         r_ras_uflow <= 1'b0;
      end else begin
         r_ras_uflow <= w_uflow;
         if (w_push) begin
            r_ras_ptr <= r_ras_ptr + RAS_AW'(1);
            if (r_ras_cnt != RAS_FULL) begin
               r_ras_cnt <= r_ras_cnt + (RAS_AW + 1)'(1);
            end
         end else if (w_pop) begin
            r_ras_ptr <= w_ras_top_idx;
            r_ras_cnt <= r_ras_cnt - (RAS_AW + 1)'(1);
         end
      end
   end

   // The stack storage needs no reset. An empty count makes any stale
   // contents unreachable.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_ras[r_ras_ptr] <= w_pc_inc;
      end
   end

   assign o_ras_uflow = r_ras_uflow;
`else
   // Without the stack, call/ret have no meaning. They are folded into a
   // sink so that the ports stay in place for a uniform interface.
   logic w_unused_ok;
   assign w_unused_ok = &{1'b0, i_call, i_ret, RAS_DEPTH[0]};
   assign o_ras_uflow = 1'b0;
`endif

   assign o_pc     = r_pc;
   assign o_pc_vld = r_pc_vld;
   assign o_epc    = r_epc;
   assign o_in_exc = r_in_exc;

endmodule

// File: tb/tb_pc_gen.sv
// ----------------------------------------------------------------------------
// tb_pc_gen -- directed, table-driven bench for pc_gen.
// A vector table covers boot, sequencing, stall, redirect, exceptions and
// wrap-around. Hand-written sequences cover the return stack (when
// PC_RAS_EN is defined) and an asynchronous reset taken in the middle of EXC.
// ----------------------------------------------------------------------------
module tb_pc_gen;

   localparam int AW = 32;
   localparam int PW = AW - 2;
   localparam int NV = 22;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          stall = 1'b0;
   logic          redirect_vld = 1'b0;
   logic [PW-1:0] redirect_pc = '0;
   logic          exc_req = 1'b0;
   logic          eret = 1'b0;
   logic          call = 1'b0;
   logic          ret = 1'b0;
   logic [PW-1:0] pc;
   logic          pc_vld;
   logic [PW-1:0] epc;
   logic          in_exc;
   logic          ras_uflow;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_gen #(
      .AW       (AW),
      .RESET_VEC(30'h0c00),
      .EXC_VEC  (30'h1060),
      .RAS_DEPTH(4)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_stall       (stall),
      .i_redirect_vld(redirect_vld),
      .i_redirect_pc (redirect_pc),
      .i_exc_req     (exc_req),
      .i_eret        (eret),
      .i_call        (call),
      .i_ret         (ret),
      .o_pc          (pc),
      .o_pc_vld      (pc_vld),
      .o_epc         (epc),
      .o_in_exc      (in_exc),
      .o_ras_uflow   (ras_uflow)
   );

   typedef struct {
      logic          stall;
      logic          rv;
      logic [PW-1:0] rpc;
      logic          exc;
      logic          eret;
      logic [PW-1:0] pc_exp;
      logic [PW-1:0] epc_exp;
      logic          exc_exp;
      logic          vld_exp;
   } vec_t;

   vec_t vt [NV];

   function automatic vec_t mk(input logic s, input logic rv, input logic [PW-1:0] rpc,
                               input logic x, input logic e, input logic [PW-1:0] pe,
                               input logic [PW-1:0] ee, input logic xe, input logic ve);
      vec_t v;
      v.stall = s; v.rv = rv; v.rpc = rpc; v.exc = x; v.eret = e;
      v.pc_exp = pe; v.epc_exp = ee; v.exc_exp = xe; v.vld_exp = ve;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
      exc_req = 1'b0; eret = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   task automatic chk_all(input string tag, input logic [PW-1:0] pe, input logic [PW-1:0] ee,
                          input logic xe, input logic ve, input logic ue);
      chk({tag, ".pc"}, 32'(pc), 32'(pe));
      chk({tag, ".epc"}, 32'(epc), 32'(ee));
      chk({tag, ".in_exc"}, 32'(in_exc), 32'(xe));
      chk({tag, ".pc_vld"}, 32'(pc_vld), 32'(ve));
      chk({tag, ".uflow"}, 32'(ras_uflow), 32'(ue));
      $display("%s: pc=%h epc=%h in_exc=%b pc_vld=%b uflow=%b",
               tag, pc, epc, in_exc, pc_vld, ras_uflow);
   endtask

   // Drive one RAS-related transaction, then check pc and uflow.
   task automatic ras_step(input string tag, input logic rv, input logic [PW-1:0] rpc,
                           input logic c, input logic r,
                           input logic [PW-1:0] pe, input logic ue);
      idle_inputs();
      redirect_vld = rv; redirect_pc = rpc; call = c; ret = r;
      step();
      chk({tag, ".pc"}, 32'(pc), 32'(pe));
      chk({tag, ".uflow"}, 32'(ras_uflow), 32'(ue));
      $display("%s: pc=%h uflow=%b", tag, pc, ras_uflow);
   endtask

   initial begin
      // Columns: stall, redir_vld, redir_pc, exc_req, eret ->
      //          pc, epc, in_exc, pc_vld
      vt[0]  = mk(0, 0, 30'h0, 0, 0, 30'h0c00, 30'h0, 0, 1);    // BOOT -> RUN
      vt[1]  = mk(0, 0, 30'h0, 0, 0, 30'h0c01, 30'h0, 0, 1);
      vt[2]  = mk(0, 0, 30'h0, 0, 0, 30'h0c02, 30'h0, 0, 1);
      vt[3]  = mk(0, 0, 30'h0, 0, 0, 30'h0c03, 30'h0, 0, 1);
      vt[4]  = mk(0, 0, 30'h0, 0, 0, 30'h0c04, 30'h0, 0, 1);
      vt[5]  = mk(0, 0, 30'h0, 0, 0, 30'h0c05, 30'h0, 0, 1);
      vt[6]  = mk(1, 0, 30'h0, 0, 0, 30'h0c05, 30'h0, 0, 1);    // stall
      vt[7]  = mk(1, 0, 30'h0, 0, 0, 30'h0c05, 30'h0, 0, 1);    // stall
      vt[8]  = mk(1, 1, 30'h0d00, 0, 0, 30'h0d00, 30'h0, 0, 1); // redirect beats stall
      vt[9]  = mk(0, 1, 30'h0c0f, 0, 0, 30'h0c0f, 30'h0, 0, 1);
      vt[10] = mk(0, 0, 30'h0, 0, 0, 30'h0c10, 30'h0, 0, 1);
      vt[11] = mk(0, 0, 30'h0, 1, 0, 30'h1060, 30'h0c10, 1, 1); // exception taken
      vt[12] = mk(0, 0, 30'h0, 1, 0, 30'h1061, 30'h0c10, 1, 1); // nested exc ignored
      vt[13] = mk(0, 0, 30'h0, 0, 1, 30'h0c10, 30'h0c10, 0, 1); // eret
      vt[14] = mk(0, 0, 30'h0, 0, 1, 30'h0c11, 30'h0c10, 0, 1); // eret in RUN ignored
      vt[15] = mk(0, 1, 30'h0d00, 1, 0, 30'h1060, 30'h0c11, 1, 1); // exc beats redirect
      vt[16] = mk(0, 1, 30'h3fffffff, 0, 0, 30'h3fffffff, 30'h0c11, 1, 1);
      vt[17] = mk(0, 0, 30'h0, 0, 0, 30'h0, 30'h0c11, 1, 1);    // wrap in EXC
      vt[18] = mk(1, 0, 30'h0, 0, 1, 30'h0c11, 30'h0c11, 0, 1); // eret beats stall
      vt[19] = mk(0, 1, 30'h3fffffff, 0, 0, 30'h3fffffff, 30'h0c11, 0, 1);
      vt[20] = mk(1, 0, 30'h0, 0, 0, 30'h3fffffff, 30'h0c11, 0, 1);
      vt[21] = mk(0, 0, 30'h0, 0, 0, 30'h0, 30'h0c11, 0, 1);    // wrap in RUN

      // Reset asserted: check the state straight away and across a clock edge.
      #2 rst_n = 1'b0;
      #1 chk_all("rst0", 30'h0c00, 30'h0, 0, 0, 0);
      step();
      step();
      chk_all("rst1", 30'h0c00, 30'h0, 0, 0, 0);
      #3 rst_n = 1'b1;       // release mid-cycle, away from the edge
      #1 chk_all("boot", 30'h0c00, 30'h0, 0, 0, 0);

      for (int i = 0; i < NV; i++) begin
         idle_inputs();
         stall = vt[i].stall; redirect_vld = vt[i].rv; redirect_pc = vt[i].rpc;
         exc_req = vt[i].exc; eret = vt[i].eret;
         step();
         chk_all($sformatf("vec%0d", i), vt[i].pc_exp, vt[i].epc_exp,
                 vt[i].exc_exp, vt[i].vld_exp, 1'b0);
      end
      idle_inputs();

`ifdef PC_RAS_EN
      // Single call/return pair.
      ras_step("ras_go",    1, 30'h0c20, 0, 0, 30'h0c20, 0);
      ras_step("ras_call",  1, 30'h2000, 1, 0, 30'h2000, 0);
      ras_step("ras_ret",   0, 30'h0,    0, 1, 30'h0c21, 0);
      // Five calls on a four-deep stack: the oldest entry (0x0c31) is lost.
      ras_step("ras_go2",   1, 30'h0c30, 0, 0, 30'h0c30, 0);
      ras_step("ras_c0",    1, 30'h2000, 1, 0, 30'h2000, 0);
      ras_step("ras_c1",    1, 30'h2010, 1, 0, 30'h2010, 0);
      ras_step("ras_c2",    1, 30'h2020, 1, 0, 30'h2020, 0);
      ras_step("ras_c3",    1, 30'h2030, 1, 0, 30'h2030, 0);
      ras_step("ras_c4",    1, 30'h2040, 1, 0, 30'h2040, 0);
      ras_step("ras_r0",    0, 30'h0,    0, 1, 30'h2031, 0);
      ras_step("ras_r1",    0, 30'h0,    0, 1, 30'h2021, 0);
      ras_step("ras_r2",    0, 30'h0,    0, 1, 30'h2011, 0);
      ras_step("ras_r3",    0, 30'h0,    0, 1, 30'h2001, 0);
      ras_step("ras_r4",    0, 30'h0,    0, 1, 30'h2002, 1);  // underflow
      ras_step("ras_idle",  0, 30'h0,    0, 0, 30'h2003, 0);  // pulse is one cycle
      // A call, a ret and a redirect together: the redirect wins and the
      // call pushes.
      ras_step("ras_cr",    1, 30'h2100, 1, 1, 30'h2100, 0);
      ras_step("ras_cr_rt", 0, 30'h0,    0, 1, 30'h2004, 0);
`endif

      // Enter EXC with a non-zero epc, then reset asynchronously in the
      // middle of the cycle.
      idle_inputs();
      redirect_vld = 1'b1; redirect_pc = 30'h0c40;
      step();
      idle_inputs();
      exc_req = 1'b1;
      step();
      idle_inputs();
      chk_all("pre_arst", 30'h1060, 30'h0c40, 1, 1, 0);
      #3 rst_n = 1'b0;
      #1 chk_all("arst", 30'h0c00, 30'h0, 0, 0, 0);
      step();
      chk_all("arst_hold", 30'h0c00, 30'h0, 0, 0, 0);
      #3 rst_n = 1'b1;
      #1 chk_all("arst_boot", 30'h0c00, 30'h0, 0, 0, 0);
      step();
      chk_all("arst_run0", 30'h0c00, 30'h0, 0, 1, 0);
      step();
      chk_all("arst_run1", 30'h0c01, 30'h0, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
